dmem_arbiter: RTL



---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU on port 0, loader on port 1.
// Define DMEM_ARB_RR_EN for round-robin contention handling; otherwise port 0 has fixed priority.

module dmem_arb_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              done,
  input  logic              rd,
  input  logic [DATA_W-1:0] ram_rd,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= done;
      // rdata is sticky: only reads that complete on this port replace it
      if (done && rd) rdata <= ram_rd;
    end
  end
endmodule

module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wd,
  input  logic [DATA_W-1:0] ram_rd
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic              owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  acc_t sel;
  logic accept;
  logic stage_v, stage_owner, stage_we;
  logic [NUM_PORTS-1:0]             ack_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_v;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;

  always_comb begin
    gnt0 = req0 & (~req1 | ~rr_ptr);
    gnt1 = req1 & (~req0 |  rr_ptr);
  end

  // the port just served yields preference to the other one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~sel.owner;
  end
`else
  always_comb begin
    gnt0 = req0;
    gnt1 = req1 & ~req0;
  end
`endif

  assign accept = gnt0 | gnt1;

  always_comb begin
    sel.owner = gnt1;
    sel.we    = gnt1 ? we1    : we0;
    sel.addr  = gnt1 ? addr1  : addr0;
    sel.wdata = gnt1 ? wdata1 : wdata0;
  end

  // access stage; address and write data hold through idle cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_v     <= 1'b0;
      stage_owner <= 1'b0;
      stage_we    <= 1'b0;
      ram_a       <= '0;
      ram_wd      <= '0;
    end else begin
      stage_v <= accept;
      if (accept) begin
        stage_owner <= sel.owner;
        stage_we    <= sel.we;
        ram_a       <= sel.addr;
        ram_wd      <= sel.wdata;
      end
    end
  end

  assign ram_we = stage_v & stage_we;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    dmem_arb_port #(.DATA_W(DATA_W)) u_port (
      .clk    (clk),
      .reset_n(reset_n),
      .done   (stage_v && (stage_owner == 1'(p))),
      .rd     (~stage_we),
      .ram_rd (ram_rd),
      .ack    (ack_v[p]),
      .rdata  (rdata_v[p])
    );
  end

  assign ack0   = ack_v[0];
  assign ack1   = ack_v[1];
  assign rdata0 = rdata_v[0];
  assign rdata1 = rdata_v[1];
endmodule
